// File: rtl/cg_axi5lite_pkg.sv
// Shared types for the cg_axi5lite register file: response codes, FSM states
// and the byte-offset width helper.
package cg_axi5lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Number of low address bits that select a byte within one register.
  function automatic int byte_off_w(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/cg_axi5lite_wr_capture.sv
// Independent AW / W holding registers. Presents the aligned write request
// (held value or same-cycle handshake) and flags when both halves are present.
module cg_axi5lite_wr_capture #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    collect_i,
  input  logic                    aw_valid_i,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [2:0]              aw_prot_i,
  output logic                    aw_ready_o,
  input  logic                    w_valid_i,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  output logic                    w_ready_o,
  output logic                    both_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [2:0]              prot_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [DATA_WIDTH/8-1:0] strb_o
);

  logic                    aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic [2:0]              aw_prot_q, aw_prot_d;
  logic                    w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
  logic                    aw_hs, w_hs;

  assign aw_ready_o = collect_i && !aw_held_q;
  assign w_ready_o  = collect_i && !w_held_q;
  assign aw_hs      = aw_valid_i && aw_ready_o;
  assign w_hs       = w_valid_i && w_ready_o;
  assign both_o     = collect_i && (aw_held_q || aw_hs) && (w_held_q || w_hs);

  assign addr_o = aw_held_q ? aw_addr_q : aw_addr_i;
  assign prot_o = aw_held_q ? aw_prot_q : aw_prot_i;
  assign data_o = w_held_q  ? w_data_q  : w_data_i;
  assign strb_o = w_held_q  ? w_strb_q  : w_strb_i;

  // A completed pair is consumed on the commit edge, so nothing is held over.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    aw_prot_d = aw_prot_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    if (both_o) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_addr_d = aw_addr_i;
        aw_prot_d = aw_prot_i;
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = w_data_i;
        w_strb_d = w_strb_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      aw_prot_q <= aw_prot_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
    end
  end

endmodule

// File: rtl/cg_axi5lite_regfile.sv
// AXI5-Lite subordinate register bank with byte strobes and SLVERR on out-of-range
// indices. Define CG_AXI5LITE_REGFILE_PROT_EN to reject unprivileged accesses.
module cg_axi5lite_regfile
  import cg_axi5lite_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           WVALID,
  output logic                           WREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic [1:0]                     BRESP,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
  output logic [NUM_REGS-1:0]            wr_stb
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = byte_off_w(DATA_WIDTH);

  wr_state_t               wr_state_q, wr_state_d;
  rd_state_t               rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0]   reg_mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]     wr_stb_q;
  resp_t                   bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    wr_collect, wr_both, wr_err, wr_commit, wr_prot_ok;
  logic [ADDR_WIDTH-1:0]   wr_addr, wr_idx;
  logic [2:0]              wr_prot;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [STRB_W-1:0]       wr_strb;
  logic                    ar_hs, rd_err, rd_prot_ok;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [DATA_WIDTH-1:0]   rd_val;
  logic                    unused_bits;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign wr_collect = (wr_state_q == W_COLLECT) && !ARESET;

  cg_axi5lite_wr_capture #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_capture (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .collect_i  (wr_collect),
    .aw_valid_i (AWVALID),
    .aw_addr_i  (AWADDR),
    .aw_prot_i  (AWPROT),
    .aw_ready_o (AWREADY),
    .w_valid_i  (WVALID),
    .w_data_i   (WDATA),
    .w_strb_i   (WSTRB),
    .w_ready_o  (WREADY),
    .both_o     (wr_both),
    .addr_o     (wr_addr),
    .prot_o     (wr_prot),
    .data_o     (wr_data),
    .strb_o     (wr_strb)
  );

`ifdef CG_AXI5LITE_REGFILE_PROT_EN
  assign wr_prot_ok = wr_prot[0];
  assign rd_prot_ok = ARPROT[0];
`else
  assign wr_prot_ok = 1'b1;
  assign rd_prot_ok = 1'b1;
`endif

  assign unused_bits = ^{wr_prot, ARPROT};

  assign wr_idx    = wr_addr >> OFFS;
  assign wr_err    = (wr_idx >= ADDR_WIDTH'(NUM_REGS)) || !wr_prot_ok;
  assign wr_commit = wr_both && !wr_err;

  assign rd_idx = ARADDR >> OFFS;
  assign rd_err = (rd_idx >= ADDR_WIDTH'(NUM_REGS)) || !rd_prot_ok;
  assign ar_hs  = ARVALID && ARREADY;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == ADDR_WIDTH'(i)) rd_val = reg_mem_q[i];
    end
  end

  // Write FSM: state register, next state, outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) wr_state_q <= W_COLLECT;
    else        wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_COLLECT: if (wr_both) wr_state_d = W_RESP;
      W_RESP:    if (BREADY)  wr_state_d = W_COLLECT;
      default:   wr_state_d = W_COLLECT;
    endcase
  end

  always_comb begin
    BVALID = (wr_state_q == W_RESP);
    BRESP  = bresp_q;
  end

  // Read FSM: state register, next state, outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) rd_state_q <= R_IDLE;
    else        rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_hs)  rd_state_d = R_DATA;
      R_DATA:  if (RREADY) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = (rd_state_q == R_IDLE) && !ARESET;
    RVALID  = (rd_state_q == R_DATA);
    RDATA   = rdata_q;
    RRESP   = rresp_q;
  end

  // Read data samples reg_mem_q before this edge's commit lands.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) reg_mem_q[i] <= RESET_VALUE;
      wr_stb_q <= '0;
      bresp_q  <= OKAY;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else begin
      wr_stb_q <= '0;
      if (wr_both) bresp_q <= wr_err ? SLVERR : OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_commit && (wr_idx == ADDR_WIDTH'(i))) begin
          reg_mem_q[i] <= merge_bytes(reg_mem_q[i], wr_data, wr_strb);
          wr_stb_q[i]  <= 1'b1;
        end
      end
      if (ar_hs) begin
        rdata_q <= rd_err ? '0 : rd_val;
        rresp_q <= rd_err ? SLVERR : OKAY;
      end
    end
  end

  assign wr_stb = wr_stb_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_q[g*DATA_WIDTH +: DATA_WIDTH] = reg_mem_q[g];
  end

endmodule

// File: tb/tb_cg_axi5lite_regfile.sv
// Self-checking bench for cg_axi5lite_regfile: directed cases then random
// reads/writes against a register-array reference model.
module tb_cg_axi5lite_regfile;

  localparam int          DW = 32;
  localparam int          AW = 32;
  localparam int          NR = 16;
  localparam logic [31:0] RV = 32'hA5A5_0000;

  logic               ACLK = 1'b0;
  logic               ARESET;
  logic               AWVALID, AWREADY;
  logic [AW-1:0]      AWADDR;
  logic [2:0]         AWPROT;
  logic               WVALID, WREADY;
  logic [DW-1:0]      WDATA;
  logic [DW/8-1:0]    WSTRB;
  logic               BVALID, BREADY;
  logic [1:0]         BRESP;
  logic               ARVALID, ARREADY;
  logic [AW-1:0]      ARADDR;
  logic [2:0]         ARPROT;
  logic               RVALID, RREADY;
  logic [DW-1:0]      RDATA;
  logic [1:0]         RRESP;
  logic [NR*DW-1:0]   regs_q;
  logic [NR-1:0]      wr_stb;

  cg_axi5lite_regfile #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_REGS    (NR),
    .RESET_VALUE (RV)
  ) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .AWADDR  (AWADDR),
    .AWPROT  (AWPROT),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .BRESP   (BRESP),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .ARADDR  (ARADDR),
    .ARPROT  (ARPROT),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .regs_q  (regs_q),
    .wr_stb  (wr_stb)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_regs [NR];
  logic [31:0] exp_q [$];
  logic [1:0]  exp_resp_q [$];
  int          stb_total = 0;
  int          stb_last = -1;

  always @(negedge ACLK) begin
    for (int i = 0; i < NR; i++) begin
      if (wr_stb[i] === 1'b1) begin
        stb_total++;
        stb_last = i;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic prot_ok(input logic [2:0] p);
`ifdef CG_AXI5LITE_REGFILE_PROT_EN
    return p[0];
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NR; i++) m_regs[i] = RV;
  endtask

  task automatic check_regs(input string tag);
    int diffs;
    diffs = 0;
    for (int i = 0; i < NR; i++) if (regs_q[i*DW +: DW] !== m_regs[i]) diffs++;
    check(tag, diffs, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_aw(input logic [31:0] addr, input logic [2:0] prot);
    logic ok;
    int   cnt;
    AWADDR = addr; AWPROT = prot; AWVALID = 1'b1;
    ok = 1'b0; cnt = 0;
    while (!ok && cnt < 20) begin
      @(negedge ACLK); ok = AWREADY;
      @(posedge ACLK); #1; cnt++;
    end
    AWVALID = 1'b0;
    if (!ok) check("aw_timeout", 0, 1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    logic ok;
    int   cnt;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    ok = 1'b0; cnt = 0;
    while (!ok && cnt < 20) begin
      @(negedge ACLK); ok = WREADY;
      @(posedge ACLK); #1; cnt++;
    end
    WVALID = 1'b0;
    if (!ok) check("w_timeout", 0, 1);
  endtask

  task automatic send_both(input logic [31:0] addr, input logic [2:0] prot,
                           input logic [31:0] data, input logic [3:0] strb);
    logic ok;
    int   cnt;
    AWADDR = addr; AWPROT = prot; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1;
    ok = 1'b0; cnt = 0;
    while (!ok && cnt < 20) begin
      @(negedge ACLK); ok = AWREADY && WREADY;
      @(posedge ACLK); #1; cnt++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    if (!ok) check("aww_timeout", 0, 1);
  endtask

  // lead > 0: W goes lead cycles before AW; lead < 0: AW goes first.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot, input int lead);
    int         idx, stb0, d;
    logic       err;
    logic [1:0] eresp;
    idx   = int'(addr >> 2);
    err   = (idx >= NR) || !prot_ok(prot);
    eresp = err ? 2'b10 : 2'b00;
    stb0  = stb_total;
    if (lead > 0) begin
      send_w(data, strb);
      repeat (lead - 1) begin
        @(negedge ACLK);
        check("wready_held", WREADY, 0);
        check("bvalid_early", BVALID, 0);
        @(posedge ACLK); #1;
      end
      send_aw(addr, prot);
    end else if (lead < 0) begin
      send_aw(addr, prot);
      repeat (-lead - 1) begin
        @(negedge ACLK);
        check("awready_held", AWREADY, 0);
        check("bvalid_early", BVALID, 0);
        @(posedge ACLK); #1;
      end
      send_w(data, strb);
    end else begin
      send_both(addr, prot, data, strb);
    end
    if (!err) m_regs[idx] = merge(m_regs[idx], data, strb);
    d = $urandom_range(0, 2);
    repeat (d) begin
      @(negedge ACLK);
      check("bvalid_hold", BVALID, 1);
      check("wr_blocked", {AWREADY, WREADY}, 0);
      @(posedge ACLK); #1;
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    check("bvalid", BVALID, 1);
    check("bresp", BRESP, eresp);
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    check("bvalid_clear", BVALID, 0);
    check("stb_count", stb_total - stb0, err ? 0 : 1);
    if (!err) check("stb_idx", stb_last, idx);
    check_regs("regs_after_write");
    @(posedge ACLK); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] prot);
    logic ok;
    int   cnt, idx, d;
    idx = int'(addr >> 2);
    ARADDR = addr; ARPROT = prot; ARVALID = 1'b1;
    ok = 1'b0; cnt = 0;
    while (!ok && cnt < 20) begin
      @(negedge ACLK); ok = ARREADY;
      @(posedge ACLK); #1; cnt++;
    end
    ARVALID = 1'b0;
    if (!ok) begin
      check("ar_timeout", 0, 1);
    end else begin
      if (idx >= NR || !prot_ok(prot)) begin
        exp_q.push_back(32'h0); exp_resp_q.push_back(2'b10);
      end else begin
        exp_q.push_back(m_regs[idx]); exp_resp_q.push_back(2'b00);
      end
      d = $urandom_range(0, 2);
      repeat (d) begin
        @(negedge ACLK);
        check("rvalid_hold", RVALID, 1);
        check("arready_busy", ARREADY, 0);
        @(posedge ACLK); #1;
      end
      RREADY = 1'b1;
      @(negedge ACLK);
      check("rvalid", RVALID, 1);
      check("rdata", RDATA, exp_q.pop_front());
      check("rresp", RRESP, exp_resp_q.pop_front());
      @(posedge ACLK); #1;
      RREADY = 1'b0;
      @(negedge ACLK);
      check("rvalid_clear", RVALID, 0);
      @(posedge ACLK); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ARESET = 1'b1;
    AWVALID = 1'b0; AWADDR = '0; AWPROT = '0;
    WVALID = 1'b0; WDATA = '0; WSTRB = '0; BREADY = 1'b0;
    ARVALID = 1'b0; ARADDR = '0; ARPROT = '0; RREADY = 1'b0;
    reset_model();

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
    check("rst_valids", {BVALID, RVALID}, 2'b00);
    check("rst_resp", {BRESP, RRESP}, 4'b0000);
    check("rst_rdata", RDATA, 0);
    check("rst_stb", wr_stb, 0);
    check_regs("rst_regs");
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("post_rst_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
    @(posedge ACLK); #1;

    do_read(32'h0C, 3'b001);
    do_write(32'h08, 32'h1234_5678, 4'hF, 3'b001, 3);
    check("reg2_value", regs_q[2*DW +: DW], 32'h1234_5678);

    do_write(32'h04, 32'hFFFF_FFFF, 4'hF, 3'b001, 0);
    do_write(32'h04, 32'h0000_0000, 4'b0101, 3'b001, -2);
    check("strb_merge", regs_q[1*DW +: DW], 32'hFF00_FF00);
    do_write(32'h06, 32'h1111_1111, 4'b0000, 3'b001, 1);

    do_write(4 * NR, $urandom, 4'hF, 3'b001, 1);
    do_read(4 * NR, 3'b001);

    // Same-edge read and write of reg 5: the read sees the old contents.
    do_write(32'h14, 32'h1, 4'hF, 3'b001, 0);
    AWADDR = 32'h14; AWPROT = 3'b001; WDATA = 32'h2; WSTRB = 4'hF;
    ARADDR = 32'h14; ARPROT = 3'b001;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    @(negedge ACLK);
    check("same_edge_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    m_regs[5] = 32'h2;
    @(negedge ACLK);
    check("same_edge_rdata", RDATA, 32'h1);
    check("same_edge_valids", {BVALID, RVALID}, 2'b11);
    check_regs("same_edge_regs");
    BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0; RREADY = 1'b0;
    @(negedge ACLK);
    check("same_edge_clear", {BVALID, RVALID}, 2'b00);
    @(posedge ACLK); #1;
    do_read(32'h14, 3'b001);

`ifdef CG_AXI5LITE_REGFILE_PROT_EN
    do_write(32'h18, 32'hDEAD_BEEF, 4'hF, 3'b000, 0);
    check("prot_no_commit", regs_q[6*DW +: DW], RV);
    do_write(32'h18, 32'hDEAD_BEEF, 4'hF, 3'b001, 0);
    check("prot_commit", regs_q[6*DW +: DW], 32'hDEAD_BEEF);
    do_read(32'h18, 3'b000);
`endif

    // Reset with a held W and then with a pending B response.
    send_w(32'hCAFE_0001, 4'hF);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    reset_model();
    @(negedge ACLK);
    check("rst_mid_readies", {AWREADY, WREADY}, 2'b11);
    check("rst_mid_bvalid", BVALID, 0);
    check_regs("rst_mid_regs");
    @(posedge ACLK); #1;
    do_write(32'h1C, 32'h0BAD_F00D, 4'hF, 3'b001, -1);
    send_both(32'h20, 3'b001, 32'h7777_7777, 4'hF);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    reset_model();
    @(negedge ACLK);
    check("rst_drop_bvalid", BVALID, 0);
    check_regs("rst_drop_regs");
    @(posedge ACLK); #1;

    for (int it = 0; it < 60; it++) begin
      logic [31:0] addr;
      logic [2:0]  prot;
      addr = 32'($urandom_range(0, NR + 2) * 4 + $urandom_range(0, 3));
      prot = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) < 2)
        do_write(addr, $urandom, 4'($urandom_range(0, 15)), prot, $urandom_range(0, 6) - 3);
      else
        do_read(addr, prot);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
